// File: rtl/matmul_operand_feeder.sv
// Operand sequencer for the matrix-multiply datapath: loads A then B row-major from one
// word stream, then issues every (row of A, column of B) pair in row-major output order.
module matmul_operand_feeder #(
  parameter int DIM = 4,
  parameter int W   = 8,
  localparam int IW = $clog2(DIM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DIM*W-1:0]   out_a,
  output logic [DIM*W-1:0]   out_b,
  output logic [IW-1:0]      out_row,
  output logic [IW-1:0]      out_col,
  output logic               out_last
);

  localparam int N       = DIM * DIM;
  localparam int LCW     = $clog2(2 * N);
  localparam int LAST_LC = 2 * N - 1;

  typedef enum logic {
    LOAD,
    STREAM
  } state_t;

  state_t         state_q, state_d;
  logic [LCW-1:0] lc_q;
  logic [IW-1:0]  i_q, j_q;
  logic [W-1:0]   a_buf [DIM][DIM];
  logic [W-1:0]   b_buf [DIM][DIM];

  logic in_fire, out_fire, load_done, stream_done, i_max, j_max;

  // Handshake qualifiers come straight from the state register, so neither ready nor
  // valid has a combinational path from the opposite side of the block.
  assign in_ready    = (state_q == LOAD);
  assign out_valid   = (state_q == STREAM);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign i_max       = (i_q == IW'(DIM - 1));
  assign j_max       = (j_q == IW'(DIM - 1));
  assign load_done   = in_fire && (lc_q == LCW'(LAST_LC));
  assign stream_done = out_fire && i_max && j_max;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (load_done)   state_d = STREAM;
    if (stream_done) state_d = LOAD;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      lc_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) lc_q <= load_done ? '0 : lc_q + LCW'(1);
      if (out_fire) begin
        if (j_max) begin
          j_q <= '0;
          i_q <= i_max ? '0 : i_q + IW'(1);
        end else begin
          j_q <= j_q + IW'(1);
        end
      end
    end
  end

  // NOTE: the operand buffers are reset on purpose: outputs must read as zero after reset,
  // and stale operands from an aborted load must never reach the datapath.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          a_buf[r][c] <= '0;
          b_buf[r][c] <= '0;
        end
      end
    end else if (in_fire) begin
      for (int r = 0; r < DIM; r++) begin
        for (int c = 0; c < DIM; c++) begin
          if (lc_q == LCW'(r * DIM + c))     a_buf[r][c] <= in_data;
          if (lc_q == LCW'(N + r * DIM + c)) b_buf[r][c] <= in_data;
        end
      end
    end
  end

  // Row i of A and column j of B, element k in slice k; i and j sit at zero outside STREAM.
  always_comb begin
    out_a = '0;
    out_b = '0;
    for (int k = 0; k < DIM; k++) begin
      out_a[k*W +: W] = a_buf[i_q][k];
      out_b[k*W +: W] = b_buf[k][j_q];
    end
  end

  assign out_row  = i_q;
  assign out_col  = j_q;
  assign out_last = out_valid && i_max && j_max;

endmodule

// File: doc/matmul_operand_feeder.md
# matmul_operand_feeder

Upstream operand sequencer for the matrix-multiply datapath. Accepts a single valid/ready word stream carrying matrix A and then matrix B, buffers both in registers, and issues every (row of A, column of B) vector pair to the downstream dot-product stage in row-major output order. Each pair carries its output coordinates and a last flag. The block alternates between a load phase and a stream phase, so one square matrix pair is in flight at a time.

## Interface
- `DIM`, default 4: matrix dimension (DIM x DIM); legal range 2..16.
- `W`, default 8: element width in bits (unsigned).
- `IW`, derived as $clog2(DIM): index width; not user-set.

- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  block can accept an input word.
- `in_data`  in  W  input element.
- `out_valid`  out  1  operand pair valid.
- `out_ready`  in  1  downstream accepts the pair.
- `out_a`  out  DIM*W  row `out_row` of A; element k at bits [k*W +: W].
- `out_b`  out  DIM*W  column `out_col` of B; element k (B[k][out_col]) at bits [k*W +: W].
- `out_row`  out  IW  output row index i.
- `out_col`  out  IW  output column index j.
- `out_last`  out  1  high when the pair is (DIM-1, DIM-1).

## Operation
- **States: LOAD and STREAM.** The block enters LOAD on reset.
- **LOAD phase**
  - `in_ready` is 1 and `out_valid` is 0.
  - A word transfers when `in_valid` && `in_ready`.
  - Load counter `lc`, range 0..2*DIM*DIM-1: word `lc` < DIM*DIM is written to A[lc/DIM][lc%DIM], i.e. A row-major.
  - Remaining words are written to B[(lc-DIM*DIM)/DIM][(lc-DIM*DIM)%DIM], i.e. B row-major.
  - When the word at `lc` = 2*DIM*DIM-1 transfers, `lc` clears and the state moves to STREAM.
- **STREAM phase**
  - `in_ready` is 0 and `out_valid` is 1.
  - Indices (i, j) start at (0, 0).
  - A pair transfers when `out_valid` && `out_ready`. On transfer, j increments. When j = DIM-1, j wraps to 0 and i increments.
  - Transfer of (DIM-1, DIM-1) returns the block to LOAD with i = j = 0.
- **Output mapping:** `out_a`, `out_b`, `out_row`, `out_col` and `out_last` are combinational decodes of the buffers and of i/j. They are stable whenever `out_valid` is 1 and `out_ready` is 0.
- **Buffers:** A and B are held unchanged during STREAM. The next LOAD overwrites them in full.
- **Width rules:** no arithmetic is applied to data; elements pass through bit-exact.
- **Reset (any time, including mid-load or mid-stream)**
  - State returns to LOAD; `lc`, i and j clear; all buffer entries become 0.
  - Outputs: `in_ready` = 1, `out_valid` = 0, `out_row` = `out_col` = 0, `out_last` = 0, `out_a` = `out_b` = 0.
  - Partially loaded or partially streamed data is discarded.
- **Idle inputs:** `in_valid` during STREAM is ignored and no word is consumed. `out_ready` during LOAD is ignored.

## Timing
- **Load throughput:** one word per cycle. A full matrix pair takes 2*DIM*DIM accepted words.
- **Load-to-stream latency:** `out_valid` rises on the clock edge that accepts the final B word, so the first pair is visible in the next cycle.
- **Stream throughput:** one pair per cycle while `out_ready` = 1, so DIM*DIM cycles minimum per matrix pair.
- **Stream-to-load:** `in_ready` rises in the cycle after the (DIM-1, DIM-1) transfer. There is no overlap of load and stream.
- **Backpressure:** `out_ready` low stalls indefinitely, with no loss or duplication of pairs.
- **Combinational paths:** `in_ready` and `out_valid` depend only on registered state. There is no combinational path from `out_ready` to `in_ready` or from `in_valid` to `out_valid`.

## Test plan
All scenarios use DIM=2, W=8.
- **Basic load and stream.** Load 1,2,3,4,5,6,7,8 back-to-back with `out_ready`=1. Required:
  - Pairs in order (0,0) a=16'h0201 b=16'h0705; (0,1) a=16'h0201 b=16'h0806; (1,0) a=16'h0403 b=16'h0705; (1,1) a=16'h0403 b=16'h0806.
  - `out_last` high only on (1,1).
  - First `out_valid` one cycle after the 8th word is accepted.
- **Backpressure.** Same load; hold `out_ready`=0 for 5 cycles at pair (0,1). Required: outputs are held constant (a=16'h0201, b=16'h0806), then the sequence resumes with no skip or repeat.
- **Gapped input.** Toggle `in_valid` every other cycle during load, and drive `in_valid`=1 during STREAM. Required: identical pair sequence to the first scenario, and `in_ready`=0 throughout STREAM.
- **Back-to-back matrix pairs.** Load a second pair (A=9..12, B=13..16) immediately after the first stream. Required: `in_ready` is 1 the cycle after the (1,1) transfer, and the second stream's first pair is a=16'h0A09 b=16'h0F0D.
- **Reset mid-stream.** Assert `reset`=0 after the (0,0) transfer. Required:
  - While `reset` is low: `out_valid`=0, `in_ready`=1, all outputs 0.
  - After release: a fresh 8-word load streams from (0,0) using only the new data.
- **Reset mid-load.** Assert `reset`=0 after 5 words. Required: `lc` clears, and the next 8 words form a complete new matrix pair with correct outputs.
